// File: rtl/prim_ram_1p_pkg_i3ccore.sv
// Shared types and helpers for the I3C core single-port RAM primitive.
package prim_ram_1p_pkg_i3ccore;

   // One flavour of hardened-macro configuration: enable plus 4-bit setting.
   typedef struct packed {
      logic       cfg_en;
      logic [3:0] cfg;
   } cfg_t;

   // Both macro flavours; the instance picks one via IsRegfile.
   typedef struct packed {
      cfg_t ram_cfg;
      cfg_t rf_cfg;
   } ram_1p_cfg_t;

   typedef enum logic {
      RamIdle,
      RamInit
   } ram_init_state_e;

   // Upper bound on word width handled by mask_expand; callers cast down.
   localparam int unsigned MaxWidth = 1024;

   // Replicate every lane-enable bit across the bits of its lane.
   function automatic logic [MaxWidth-1:0] mask_expand(input logic [MaxWidth-1:0] lane_mask,
                                                       input int unsigned bits_per_lane);
      logic [MaxWidth-1:0] bit_mask;
      bit_mask = '0;
      for (int unsigned i = 0; i < MaxWidth; i++) begin
         bit_mask[i] = lane_mask[i / bits_per_lane];
      end
      return bit_mask;
   endfunction

endpackage

// File: rtl/prim_ram_1p_array_i3ccore.sv
// Bare behavioural storage array: bit-masked write, combinational read.
// This is the module a hardened macro replaces; it has no reset on purpose.
module prim_ram_1p_array_i3ccore #(
   parameter int Width = 32,
   parameter int Depth = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [Width-1:0] wdata,
   input  logic [Width-1:0] bmask,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem [Depth];

   // Masked write: only bits with bmask set take the new data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/prim_ram_1p_init_i3ccore.sv
// Single-port RAM with req/gnt handshake, lane write mask, range check,
// selectable read latency, zeroization sweep and registered macro config.
module prim_ram_1p_init_i3ccore
   import prim_ram_1p_pkg_i3ccore::*;
#(
   parameter int Width           = 32,
   parameter int Depth           = 64,
   parameter int DataBitsPerMask = 8,
   parameter bit OutputReg       = 1,
   parameter bit InitOnReset     = 1,
   parameter bit IsRegfile       = 0,
   localparam int AW    = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int Lanes = Width / DataBitsPerMask
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic             write_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [Lanes-1:0] wmask_i,
   output logic             rvalid_o,
   output logic [Width-1:0] rdata_o,
   output logic             rerr_o,
   input  logic             init_req_i,
   output logic             init_busy_o,
   output logic             init_done_o,
   input  ram_1p_cfg_t      cfg_i,
   output cfg_t             cfg_o
);

   localparam logic [AW:0]   DepthExt = (AW+1)'(Depth);
   localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

   ram_init_state_e state, state_next;
   logic [AW-1:0]   init_cnt, init_cnt_next;

   logic             in_range;
   logic             rd_req;
   logic             arr_we;
   logic [AW-1:0]    arr_addr;
   logic [Width-1:0] arr_wdata;
   logic [Width-1:0] arr_bmask;
   logic [Width-1:0] arr_rdata;
   cfg_t             cfg_sel;

   // Non-power-of-two depths leave a hole at the top of the address space.
   assign in_range    = {1'b0, addr_i} < DepthExt;
   assign gnt_o       = req_i & (state == RamIdle) & ~init_req_i & ~rst_i;
   assign init_busy_o = (state == RamInit);
   assign rd_req      = gnt_o & ~write_i;

   // The sweep owns the array port while busy; out-of-range writes are dropped.
   assign arr_we    = ~rst_i & (init_busy_o | (gnt_o & write_i & in_range));
   assign arr_addr  = init_busy_o ? init_cnt : addr_i;
   assign arr_wdata = init_busy_o ? '0 : wdata_i;
   assign arr_bmask = init_busy_o ? '1
                                  : Width'(mask_expand(MaxWidth'(wmask_i), DataBitsPerMask));

   prim_ram_1p_array_i3ccore #(
      .Width (Width),
      .Depth (Depth),
      .AW    (AW)
   ) u_array (
      .clk   (clk_i),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .bmask (arr_bmask),
      .rdata (arr_rdata)
   );

   // FSM state and sweep address registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= InitOnReset ? RamInit : RamIdle;
         init_cnt <= '0;
      end else begin
         state    <= state_next;
         init_cnt <= init_cnt_next;
      end
   end

   // Next state: sweep runs to the last word, init requests only start from idle.
   always_comb begin
      state_next    = state;
      init_cnt_next = init_cnt;
      case (state)
         RamInit: begin
            if (init_cnt == LastAddr) begin
               state_next    = RamIdle;
               init_cnt_next = '0;
            end else begin
               init_cnt_next = init_cnt + AW'(1);
            end
         end
         RamIdle: begin
            if (init_req_i) begin
               state_next    = RamInit;
               init_cnt_next = '0;
            end
         end
         default: state_next = RamIdle;
      endcase
   end

   // Sticky completion flag, set on the sweep's final write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         init_done_o <= 1'b0;
      end else if ((state == RamInit) && (state_next == RamIdle)) begin
         init_done_o <= 1'b1;
      end
   end

   assign cfg_sel = IsRegfile ? cfg_i.rf_cfg : cfg_i.ram_cfg;

   // Capture the selected macro configuration whenever its enable is set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_o <= '0;
      end else if (cfg_sel.cfg_en) begin
         cfg_o <= cfg_sel;
      end
   end

   // ---- stage p1: read data captured one cycle after the grant ----
   logic             vld_p1;
   logic             err_p1;
   logic [Width-1:0] rdata_p1;

   // Read stage 1; data holds between reads, out-of-range reads return zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         rdata_p1 <= '0;
      end else begin
         vld_p1 <= rd_req;
         err_p1 <= rd_req & ~in_range;
         if (rd_req) begin
            rdata_p1 <= in_range ? arr_rdata : '0;
         end
      end
   end

   // ---- stage p2: optional output register ----
   if (OutputReg) begin : g_out_reg
      logic             vld_p2;
      logic             err_p2;
      logic [Width-1:0] rdata_p2;

      // Output register; loads only behind a valid so rdata_o holds otherwise.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
         end else begin
            vld_p2 <= vld_p1;
            err_p2 <= err_p1;
            if (vld_p1) begin
               rdata_p2 <= rdata_p1;
            end
         end
      end

      assign rvalid_o = vld_p2;
      assign rerr_o   = err_p2;
      assign rdata_o  = rdata_p2;
   end else begin : g_out_p1
      assign rvalid_o = vld_p1;
      assign rerr_o   = err_p1;
      assign rdata_o  = rdata_p1;
   end

endmodule

// File: tb/tb_prim_ram_1p_init_i3ccore.sv
// Bench for prim_ram_1p_init_i3ccore: two instances share one stimulus
// stream (A: Depth 64, latency 2, ram flavour; B: Depth 48, latency 1,
// regfile flavour) and are compared every cycle against an array model.
module tb_prim_ram_1p_init_i3ccore;
   import prim_ram_1p_pkg_i3ccore::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        write = 1'b0;
   logic        init_req = 1'b0;
   logic [5:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   ram_1p_cfg_t cfg_in = '0;

   logic [1:0]       gnt_d, rvalid_d, rerr_d, busy_d, done_d;
   logic [1:0][31:0] rdata_d;
   cfg_t             cfg_d [2];

   always #5 clk = ~clk;

   prim_ram_1p_init_i3ccore #(
      .Width(32), .Depth(64), .DataBitsPerMask(8),
      .OutputReg(1'b1), .InitOnReset(1'b1), .IsRegfile(1'b0)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_d[0]),
      .write_i(write), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
      .rvalid_o(rvalid_d[0]), .rdata_o(rdata_d[0]), .rerr_o(rerr_d[0]),
      .init_req_i(init_req), .init_busy_o(busy_d[0]), .init_done_o(done_d[0]),
      .cfg_i(cfg_in), .cfg_o(cfg_d[0])
   );

   prim_ram_1p_init_i3ccore #(
      .Width(32), .Depth(48), .DataBitsPerMask(8),
      .OutputReg(1'b0), .InitOnReset(1'b1), .IsRegfile(1'b1)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_d[1]),
      .write_i(write), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
      .rvalid_o(rvalid_d[1]), .rdata_o(rdata_d[1]), .rerr_o(rerr_d[1]),
      .init_req_i(init_req), .init_busy_o(busy_d[1]), .init_done_o(done_d[1]),
      .cfg_i(cfg_in), .cfg_o(cfg_d[1])
   );

   // ---------------- reference model ----------------
   int          m_depth [2] = '{64, 48};
   int          m_lat   [2] = '{2, 1};
   bit          m_rf    [2] = '{1'b0, 1'b1};
   logic [31:0] m_mem   [2][64];
   bit          m_busy [2], m_done [2];
   int          m_pos  [2];
   bit          s_v [2], s_e [2], o_v [2], o_e [2];
   logic [31:0] s_d [2], o_d [2], last_d [2];
   cfg_t        m_cfg [2];
   bit          last_gnt [2];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic bit model_gnt(int i);
      return req && !m_busy[i] && !init_req && !rst;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b1; m_done[i] = 1'b0; m_pos[i] = 0;
         s_v[i] = 1'b0; s_e[i] = 1'b0; s_d[i] = '0;
         o_v[i] = 1'b0; o_e[i] = 1'b0; o_d[i] = '0;
         last_d[i] = '0; m_cfg[i] = '0;
         for (int a = 0; a < 64; a++) m_mem[i][a] = '0;
      end
   endtask

   // One clock edge of the model, using the inputs present before the edge.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit g, rd, inr;
         logic [31:0] nd;
         cfg_t sel;
         g   = model_gnt(i);
         rd  = g && !write;
         inr = (int'(addr) < m_depth[i]);
         nd  = (rd && inr) ? m_mem[i][addr] : 32'h0;
         if (m_lat[i] == 1) begin
            o_v[i] = rd; o_d[i] = nd; o_e[i] = rd && !inr;
         end else begin
            o_v[i] = s_v[i]; o_d[i] = s_d[i]; o_e[i] = s_e[i];
            s_v[i] = rd; s_d[i] = nd; s_e[i] = rd && !inr;
         end
         if (o_v[i]) last_d[i] = o_d[i];
         if (m_busy[i]) begin
            m_mem[i][m_pos[i]] = '0;
            m_pos[i]++;
            if (m_pos[i] == m_depth[i]) begin
               m_busy[i] = 1'b0; m_done[i] = 1'b1; m_pos[i] = 0;
            end
         end else if (init_req) begin
            m_busy[i] = 1'b1; m_pos[i] = 0;
         end else if (g && write && inr) begin
            for (int k = 0; k < 4; k++)
               if (wmask[k]) m_mem[i][addr][k*8 +: 8] = wdata[k*8 +: 8];
         end
         sel = m_rf[i] ? cfg_in.rf_cfg : cfg_in.ram_cfg;
         if (sel.cfg_en) m_cfg[i] = sel;
      end
   endtask

   task automatic compare_post();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rvalid[%0d]", i), 32'(rvalid_d[i]), 32'(o_v[i]));
         chk($sformatf("rdata[%0d]", i), rdata_d[i], last_d[i]);
         if (o_v[i]) chk($sformatf("rerr[%0d]", i), 32'(rerr_d[i]), 32'(o_e[i]));
         chk($sformatf("busy[%0d]", i), 32'(busy_d[i]), 32'(m_busy[i]));
         chk($sformatf("done[%0d]", i), 32'(done_d[i]), 32'(m_done[i]));
         chk($sformatf("cfg[%0d]", i), 32'(cfg_d[i]), 32'(m_cfg[i]));
      end
   endtask

   // One cycle: check grant before the edge, step model, check outputs at negedge.
   task automatic cycle();
      #1;
      for (int i = 0; i < 2; i++) begin
         last_gnt[i] = gnt_d[i];
         chk($sformatf("gnt[%0d]", i), 32'(gnt_d[i]), 32'(model_gnt(i)));
      end
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      compare_post();
   endtask

   task automatic op(bit r, bit w, logic [5:0] a, logic [31:0] d, logic [3:0] m);
      req = r; write = w; addr = a; wdata = d; wmask = m;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_busy", 32'(busy_d), 32'h3);
      chk("rst_done", 32'(done_d), 32'h0);
      chk("rst_rvalid", 32'(rvalid_d), 32'h0);
      chk("rst_rdata_a", rdata_d[0], 32'h0);
      chk("rst_rdata_b", rdata_d[1], 32'h0);
      chk("rst_cfg_a", 32'(cfg_d[0]), 32'h0);
      chk("rst_cfg_b", 32'(cfg_d[1]), 32'h0);
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // Run until both sweeps finish, counting busy cycles per instance.
   task automatic count_sweep(input int exp_a, input int exp_b);
      int cnt_a, cnt_b;
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 200 && (busy_d != 2'b00); k++) begin
         req = 1'b1; write = 1'b0; addr = 6'($urandom);
         cnt_a += int'(busy_d[0]);
         cnt_b += int'(busy_d[1]);
         cycle();
      end
      chk("sweep_len_a", 32'(cnt_a), 32'(exp_a));
      chk("sweep_len_b", 32'(cnt_b), 32'(exp_b));
      chk("sweep_done", 32'(done_d), 32'h3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      model_reset();
      req = 1'b1;
      cycle();
      cycle();
      chk("reset_busy", 32'(busy_d), 32'h3);
      chk("reset_gnt", 32'(gnt_d), 32'h0);
      rst = 1'b0;

      // Power-on sweep, then every word reads back zero.
      count_sweep(64, 48);
      for (int a = 0; a < 64; a++) op(1, 0, 6'(a), 32'h0, 4'h0);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      op(0, 0, 6'd0, 32'h0, 4'h0);

      // Lane-masked merge and read latency.
      op(1, 1, 6'd5, 32'hA5A5A5A5, 4'b1111);
      op(1, 1, 6'd5, 32'h12345678, 4'b0101);
      op(1, 0, 6'd5, 32'h0, 4'h0);
      chk("lat1_vld_b", 32'(rvalid_d[1]), 32'h1);
      chk("lat1_vld_a", 32'(rvalid_d[0]), 32'h0);
      chk("merge_b", rdata_d[1], 32'hA534A578);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("lat2_vld_a", 32'(rvalid_d[0]), 32'h1);
      chk("merge_a", rdata_d[0], 32'hA534A578);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("hold_a", rdata_d[0], 32'hA534A578);

      // Out-of-range on the 48-deep instance, in range on the 64-deep one.
      op(1, 1, 6'd50, 32'hFFFFFFFF, 4'hF);
      op(1, 0, 6'd50, 32'h0, 4'h0);
      chk("oor_vld_b", 32'(rvalid_d[1]), 32'h1);
      chk("oor_data_b", rdata_d[1], 32'h0);
      chk("oor_err_b", 32'(rerr_d[1]), 32'h1);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("inr_data_a", rdata_d[0], 32'hFFFFFFFF);
      chk("inr_err_a", 32'(rerr_d[0]), 32'h0);
      op(1, 0, 6'd47, 32'h0, 4'h0);
      chk("a47_err_b", 32'(rerr_d[1]), 32'h0);

      // Back-to-back reads in address order.
      op(1, 1, 6'd1, 32'h11111111, 4'hF);
      op(1, 1, 6'd2, 32'h22222222, 4'hF);
      op(1, 1, 6'd3, 32'h33333333, 4'hF);
      op(1, 0, 6'd1, 32'h0, 4'h0);
      chk("b2b1_b", rdata_d[1], 32'h11111111);
      op(1, 0, 6'd2, 32'h0, 4'h0);
      chk("b2b2_b", rdata_d[1], 32'h22222222);
      chk("b2b1_a", rdata_d[0], 32'h11111111);
      op(1, 0, 6'd3, 32'h0, 4'h0);
      chk("b2b3_b", rdata_d[1], 32'h33333333);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("b2b3_a", rdata_d[0], 32'h33333333);

      // Configuration flavour selection.
      cfg_in.ram_cfg = '{cfg_en: 1'b1, cfg: 4'h9};
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("cfg_ram_a", 32'(cfg_d[0]), 32'h19);
      chk("cfg_ram_b", 32'(cfg_d[1]), 32'h00);
      cfg_in.rf_cfg = '{cfg_en: 1'b1, cfg: 4'h3};
      op(0, 0, 6'd0, 32'h0, 4'h0);
      chk("cfg_rf_a", 32'(cfg_d[0]), 32'h19);
      chk("cfg_rf_b", 32'(cfg_d[1]), 32'h13);
      cfg_in = '0;
      op(0, 0, 6'd0, 32'h0, 4'h0);

      // Reset in the middle of a sweep, then the sweep restarts from 0.
      init_req = 1'b1;
      op(0, 0, 6'd0, 32'h0, 4'h0);
      init_req = 1'b0;
      for (int k = 0; k < 20; k++) op(0, 0, 6'd0, 32'h0, 4'h0);
      do_reset();
      count_sweep(64, 48);

      // Init request beats a simultaneous access; held request waits out the sweep.
      req = 1'b1; write = 1'b0; addr = 6'd7; init_req = 1'b1;
      cycle();
      chk("init_wins_a", 32'(last_gnt[0]), 32'h0);
      chk("init_wins_b", 32'(last_gnt[1]), 32'h0);
      init_req = 1'b0;
      n = 0; seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         cycle();
         if (last_gnt[0]) seen = 1'b1;
         else n++;
      end
      chk("held_req_wait_a", 32'(n), 32'd64);
      op(0, 0, 6'd0, 32'h0, 4'h0);
      op(0, 0, 6'd0, 32'h0, 4'h0);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         req      = ($urandom_range(0, 3) != 0);
         write    = 1'($urandom_range(0, 1));
         addr     = 6'($urandom);
         wdata    = $urandom;
         wmask    = 4'($urandom);
         init_req = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) cfg_in = 10'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prim_ram_1p_init_i3ccore.md
Name: prim_ram_1p_init_i3ccore

Overview:
Parametrised single-port SRAM/regfile primitive with a req/gnt handshake, per-lane write masking and a selectable read pipeline depth. It adds a zeroization sweep, run automatically after reset and on request, and registers the macro configuration (ram vs regfile flavour) for the hardened-macro hook. It backs the I3C core's TTI/HCI descriptor and data queues.

Parameters:
Width, 32, data word width in bits
Depth, 64, number of words; need not be a power of two
DataBitsPerMask, 8, bits per write-mask lane; Width must be a multiple of it
OutputReg, 1, 0 gives read latency 1; 1 adds an output register for read latency 2
InitOnReset, 1, 1 starts a zeroization sweep on reset release
IsRegfile, 0, 1 selects cfg_i.rf_cfg; 0 selects cfg_i.ram_cfg

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_i  in  1  access request
gnt_o  out  1  access accepted this cycle (combinational)
write_i  in  1  1 = write, 0 = read
addr_i  in  AW=max(1,$clog2(Depth))  word address
wdata_i  in  Width  write data
wmask_i  in  Width/DataBitsPerMask  write-lane enables
rvalid_o  out  1  read data valid (1-cycle pulse)
rdata_o  out  Width  read data
rerr_o  out  1  qualifies rvalid_o: the address was out of range
init_req_i  in  1  start a zeroization sweep (level-sampled)
init_busy_o  out  1  sweep in progress
init_done_o  out  1  sticky: at least one sweep has completed since reset
cfg_i  in  ram_1p_cfg_t  macro configuration, both flavours
cfg_o  out  cfg_t  registered, selected flavour configuration

Behaviour:
- Reset values: gnt_o=0 while in reset; rvalid_o=0, rdata_o=0, rerr_o=0, init_done_o=0, cfg_o=0. init_busy_o=InitOnReset. The memory array itself is never reset.
- FSM states and transitions:
  - INIT -> IDLE after writing address Depth-1.
  - IDLE -> INIT when init_req_i=1.
  - Reset state is INIT if InitOnReset, else IDLE.
- INIT sweep:
  - Sweep counter starts at 0 and writes all-zero words to addresses 0..Depth-1, one per cycle, so a sweep lasts Depth cycles.
  - init_done_o sets on the cycle the FSM enters IDLE from INIT.
  - init_req_i is ignored while in INIT; no restart.
- gnt_o = req_i & (state==IDLE) & ~init_req_i. Init wins over a simultaneous req_i; the request is not granted and must be held by the requester.
- Granted write:
  - Each lane k where wmask_i[k]=1 updates bits [k*DataBitsPerMask +: DataBitsPerMask]; other lanes keep their value.
  - Produces no rvalid_o.
- Granted read, OutputReg=0: rvalid_o=1 on cycle T+1 with rdata_o = mem[addr] as sampled at T.
- Granted read, OutputReg=1: rvalid_o=1 on cycle T+2.
  - The pipeline accepts back-to-back reads, one per cycle, with no bubbles.
  - rdata_o holds its last value when rvalid_o=0.
- Read-during-write is not possible (single port). A read following a write to the same address returns the new data.
- Out-of-range address (addr_i >= Depth, possible only when Depth is not a power of two):
  - A write is dropped.
  - A read returns rdata_o=0 with rerr_o=1, at normal latency.
- cfg_o is updated from the selected flavour of cfg_i every cycle where the selected cfg_en=1; otherwise it holds. cfg_o updates are allowed in any FSM state.
- Async reset mid-sweep or mid-read:
  - Pipeline valids clear immediately.
  - The FSM returns to its reset state and the sweep restarts at address 0 when InitOnReset.
  - Memory contents are undefined except as subsequently zeroized.

Decomposition:
- Package prim_ram_1p_pkg_i3ccore keeps cfg_t and ram_1p_cfg_t and adds:
  - typedef ram_init_state_e {RamIdle, RamInit}
  - function mask_expand(), which turns a lane mask into a bit mask.
- One sub-module: prim_ram_1p_array_i3ccore, the bare behavioural array (clk, we, addr, wdata, bit mask, rdata). It is the hook for hardened-macro substitution. FSM, arbitration, range check and pipeline stay in the top level.

Test Plan:
- InitOnReset=1, Depth=64: release reset -> init_busy_o=1 for exactly 64 cycles, gnt_o=0 throughout, then init_done_o=1; reading addresses 0..63 returns 0x00000000.
- Write addr 5 data 0xA5A5A5A5 mask 4'b1111, then write addr 5 data 0x12345678 mask 4'b0101, then read addr 5 -> rdata 0xA534A578, with rvalid_o exactly 2 cycles after the read grant (OutputReg=1).
- OutputReg=0: back-to-back reads of addresses 1,2,3 over 3 cycles -> rvalid_o high for 3 consecutive cycles starting T+1, returning the data in address order.
- Depth=48: write addr 50 with 0xFFFFFFFF, then read addr 50 -> rdata_o=0 and rerr_o=1; read addr 47 -> rerr_o=0.
- Assert req_i and init_req_i together in IDLE -> gnt_o=0, sweep starts; req_i held -> granted on the first cycle after the sweep completes.
- Assert reset at sweep address 20 -> all outputs return to reset values; after release the sweep restarts at 0. cfg_i.ram_cfg={1,4'h9} with IsRegfile=0 -> cfg_o=5'h19 next cycle; a change to rf_cfg alone leaves cfg_o unchanged.
